// File: rtl/debounce_pkg.sv
// Shared types and constants for the button debouncer.
package debounce_pkg;

   localparam int MS_PER_S = 1000;

   typedef enum logic [1:0] {
      LOW     = 2'd0,
      TO_HIGH = 2'd1,
      HIGH    = 2'd2,
      TO_LOW  = 2'd3
   } db_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; cleared to 0 on reset.
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule

// File: rtl/btn_debounce.sv
// Button debouncer: 2-flop sync, then level must hold STABLE+1 samples before it flips.
// Define BTN_DEBOUNCE_TOGGLE_EN to enable the press-toggle output; otherwise toggle is tied 0.
module btn_debounce
   import debounce_pkg::*;
#(
   parameter int fpga_freq   = 50_000_000,
   parameter int debounce_ms = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic rise,
   output logic fall,
   output logic toggle
);

   localparam int STABLE_RAW = fpga_freq / MS_PER_S * debounce_ms;
   localparam int STABLE     = (STABLE_RAW < 1) ? 1 : STABLE_RAW;
   localparam int CNT_W      = $clog2(STABLE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);

   logic             w_s;
   db_state_t        r_state;
   db_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_rise_nxt;
   logic             w_fall_nxt;
   logic             w_level_nxt;
   logic             r_level;
   logic             r_rise;
   logic             r_fall;

   sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn),
      .q   (w_s)
   );

   // cnt restarts at 0 on every state change, so it only ever counts a single run
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
         LOW: begin
            if (w_s) w_state_nxt = TO_HIGH;
         end
         TO_HIGH: begin
            if (!w_s) begin
               w_state_nxt = LOW;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = HIGH;
               w_rise_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         HIGH: begin
            if (!w_s) w_state_nxt = TO_LOW;
         end
         TO_LOW: begin
            if (w_s) begin
               w_state_nxt = HIGH;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = LOW;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = LOW;
      endcase
   end

   assign w_level_nxt = (w_state_nxt == HIGH) || (w_state_nxt == TO_LOW);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= LOW;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   assign level = r_level;
   assign rise  = r_rise;
   assign fall  = r_fall;

`ifdef BTN_DEBOUNCE_TOGGLE_EN
   logic r_toggle;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_toggle <= 1'b0;
      end else if (r_rise) begin
         r_toggle <= ~r_toggle;
      end
   end

   assign toggle = r_toggle;
`else
   assign toggle = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboarded bench for btn_debounce at fpga_freq=4000, debounce_ms=1 (STABLE=4).
module tb_btn_debounce;

   localparam int STABLE = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn = 1'b0;
   logic level;
   logic rise;
   logic fall;
   logic toggle;

   always #5 clk = ~clk;

   btn_debounce #(
      .fpga_freq   (4000),
      .debounce_ms (1)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn    (btn),
      .level  (level),
      .rise   (rise),
      .fall   (fall),
      .toggle (toggle)
   );

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
      logic toggle;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec   = 0;
   int   n_err   = 0;
   bit   started = 1'b0;

   // Reference model: btn reaches the decision point two edges after sampling;
   // the debounced level flips once the sample has disagreed with it STABLE+1 edges running.
   bit   dly_q[$];
   int   m_run;
   logic m_level;
   logic m_tog;
   logic m_rise_prev;

   task automatic model_step();
      exp_t e;
      bit   s;
      e = '0;
      if (!rst) begin
         dly_q.delete();
         dly_q.push_back(1'b0);
         dly_q.push_back(1'b0);
         m_run       = 0;
         m_level     = 1'b0;
         m_tog       = 1'b0;
         m_rise_prev = 1'b0;
         started     = 1'b1;
      end else if (started) begin
         s = dly_q.pop_front();
         dly_q.push_back(btn);
`ifdef BTN_DEBOUNCE_TOGGLE_EN
         if (m_rise_prev) m_tog = ~m_tog;
`endif
         if (s != m_level) m_run++;
         else              m_run = 0;
         if (m_run == STABLE + 1) begin
            m_level = ~m_level;
            m_run   = 0;
            e.rise  = m_level;
            e.fall  = ~m_level;
         end
         e.level     = m_level;
         e.toggle    = m_tog;
         m_rise_prev = e.rise;
      end
      if (started) exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (started) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL scoreboard_empty: got no expectation, required one at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("sb_level",  level,  e.level);
               chk("sb_rise",   rise,   e.rise);
               chk("sb_fall",   fall,   e.fall);
               chk("sb_toggle", toggle, e.toggle);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic v, input int n);
      btn = v;
      repeat (n) tick();
   endtask

   logic exp_tog1;

   initial begin
`ifdef BTN_DEBOUNCE_TOGGLE_EN
      exp_tog1 = 1'b1;
`else
      exp_tog1 = 1'b0;
`endif
      rst = 1'b0;
      btn = 1'b0;
      tick();
      chk("reset_level", level, 1'b0);
      chk("reset_rise",  rise,  1'b0);
      chk("reset_toggle", toggle, 1'b0);
      tick();
      rst = 1'b1;
      hold(1'b0, 4);

      // clean press: first sampled at edge k, level/rise expected at k+6
      btn = 1'b1;
      repeat (5) tick();
      tick();
      chk("press_k5_level", level, 1'b0);
      tick();
      chk("press_k6_level", level, 1'b1);
      chk("press_k6_rise",  rise,  1'b1);
      tick();
      chk("press_k7_rise",   rise,   1'b0);
      chk("press_k7_toggle", toggle, exp_tog1);
      hold(1'b1, 4);

      // release
      btn = 1'b0;
      repeat (6) tick();
      chk("release_k5_level", level, 1'b1);
      tick();
      chk("release_k6_level", level, 1'b0);
      chk("release_k6_fall",  fall,  1'b1);
      tick();
      chk("release_k7_fall", fall, 1'b0);
      hold(1'b0, 4);

      // bounce: three-sample highs never meet the stable window
      for (int i = 0; i < 5; i++) begin
         hold(1'b1, 3);
         hold(1'b0, 1);
      end
      hold(1'b0, 10);
      chk("bounce_level", level, 1'b0);

      // second clean press and release
      hold(1'b1, 12);
      chk("press2_level", level, 1'b1);
      chk("press2_toggle", toggle, 1'b0);
      hold(1'b0, 12);

      // reset while TO_HIGH with cnt=2, then a fresh debounce with btn still high
      btn = 1'b1;
      repeat (5) tick();
      rst = 1'b0;
      tick();
      chk("midrst_level", level, 1'b0);
      chk("midrst_rise",  rise,  1'b0);
      rst = 1'b1;
      hold(1'b1, 12);
      chk("postrst_level", level, 1'b1);
      hold(1'b0, 12);

      // randomized segments with occasional resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b0;
            tick();
            rst = 1'b1;
         end
         hold(1'($urandom_range(0, 1)), $urandom_range(1, 9));
      end
      hold(1'b0, 10);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
